// File: rtl/sensor_capture_pkg.sv
// Shared types for the sensor capture front end: FSM state encoding and FIFO level sizing.
package sensor_capture_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_ABORT   = 2'd3
   } state_t;

   // Occupancy counter must hold 0..depth inclusive.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sensor_capture_frontend_fifo.sv
// First-word-fall-through synchronous FIFO; full/empty are decoded from the occupancy register.
module sync_fifo_fwft
   import sensor_capture_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [DATA_W-1:0]             push_data,
   input  logic                          pop,
   input  logic                          flush,
   output logic [DATA_W-1:0]             pop_data,
   output logic                          full,
   output logic                          empty,
   output logic [level_width(DEPTH)-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = level_width(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
   localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1'b1);
   localparam logic [LVL_W-1:0] LVL_DEPTH = LVL_W'(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [LVL_W-1:0]  level_r;
   logic              full_s;
   logic              empty_s;
   logic              do_push_s;
   logic              do_pop_s;

   // A push into a full FIFO succeeds only when a pop frees the slot in the same cycle.
   always_comb begin
      full_s    = (level_r == LVL_DEPTH);
      empty_s   = (level_r == {LVL_W{1'b0}});
      do_pop_s  = pop && !empty_s;
      do_push_s = push && (!full_s || do_pop_s);
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         if (do_push_s && !do_pop_s) begin
            level_r <= level_r + LVL_ONE;
         end else if (do_pop_s && !do_push_s) begin
            level_r <= level_r - LVL_ONE;
         end
      end
   end

   // Storage array; contents are only observable through the occupancy-gated read port.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign pop_data = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];
   assign full     = full_s;
   assign empty    = empty_s;
   assign level    = level_r;

endmodule

// File: rtl/sensor_capture_frontend.sv
// Sensor burst capture: synchronisers, sample prescaler, burst FSM and FWFT buffer.
// Optional build macro SENSOR_DEDUP_EN suppresses pushes of a sample equal to the last stored word.
module sensor_capture_frontend
   import sensor_capture_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int FIFO_DEPTH  = 16,
   parameter int CLK_DIV     = 64,
   parameter int NUM_SAMPLES = 256
) (
   input  logic                               wb_clk_i,
   input  logic                               wb_rst_ni,
   input  logic                               start_logging,
   input  logic [DATA_W-1:0]                  sensor_pad_i,
   input  logic                               power_fail_i,
   output logic                               out_valid_o,
   output logic [DATA_W-1:0]                  out_data_o,
   input  logic                               out_ready_i,
   output logic                               busy_o,
   output logic                               done_o,
   output logic                               fail_o,
   output logic                               overflow_o,
   output logic [level_width(FIFO_DEPTH)-1:0] level_o
);

   localparam int LVL_W = level_width(FIFO_DEPTH);
   localparam int PRE_W = $clog2(CLK_DIV);
   localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

   logic [DATA_W-1:0] pad_meta_r;
   logic [DATA_W-1:0] pad_sync_r;
   logic              pf_meta_r;
   logic              pf_sync_r;

   state_t            state_r;
   state_t            state_nx_s;
   logic [PRE_W-1:0]  presc_r;
   logic [PRE_W-1:0]  presc_nx_s;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  count_nx_s;
   logic              fail_r;
   logic              fail_nx_s;
   logic              ovf_r;
   logic              ovf_nx_s;

   logic              tick_s;
   logic              skip_s;
   logic              push_s;
   logic              pop_s;
   logic              flush_s;
   logic              done_s;
   logic              burst_entry_s;
   logic              valid_s;
   logic              full_s;
   logic              empty_s;
   logic [DATA_W-1:0] fifo_data_s;
   logic [LVL_W-1:0]  level_s;

   // Two-flop synchronisers for the asynchronous pads.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         pad_meta_r <= {DATA_W{1'b0}};
         pad_sync_r <= {DATA_W{1'b0}};
         pf_meta_r  <= 1'b0;
         pf_sync_r  <= 1'b0;
      end else begin
         pad_meta_r <= sensor_pad_i;
         pad_sync_r <= pad_meta_r;
         pf_meta_r  <= power_fail_i;
         pf_sync_r  <= pf_meta_r;
      end
   end

   // Words are hidden during the flush cycle so nothing is handed over from a dead burst.
   always_comb begin
      valid_s = !empty_s && (state_r != ST_ABORT);
      pop_s   = valid_s && out_ready_i;
      tick_s  = (state_r == ST_CAPTURE) && (presc_r == PRE_LAST);
   end

   // Burst FSM; power-fail outranks any tick or completion in the same cycle.
   always_comb begin
      state_nx_s    = state_r;
      presc_nx_s    = presc_r;
      count_nx_s    = count_r;
      fail_nx_s     = fail_r;
      ovf_nx_s      = ovf_r;
      push_s        = 1'b0;
      flush_s       = 1'b0;
      done_s        = 1'b0;
      burst_entry_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_logging && !pf_sync_r) begin
               state_nx_s    = ST_CAPTURE;
               presc_nx_s    = {PRE_W{1'b0}};
               count_nx_s    = {CNT_W{1'b0}};
               fail_nx_s     = 1'b0;
               ovf_nx_s      = 1'b0;
               burst_entry_s = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            if (pf_sync_r) begin
               state_nx_s = ST_ABORT;
            end else if (tick_s) begin
               presc_nx_s = {PRE_W{1'b0}};
               count_nx_s = count_r + CNT_ONE;
               if (skip_s) begin
                  push_s = 1'b0;
               end else if (full_s && !pop_s) begin
                  ovf_nx_s = 1'b1;
               end else begin
                  push_s = 1'b1;
               end
               if (count_r == CNT_LAST) begin
                  state_nx_s = ST_DRAIN;
               end else begin
                  state_nx_s = ST_CAPTURE;
               end
            end else begin
               presc_nx_s = presc_r + PRE_ONE;
            end
         end
         ST_DRAIN: begin
            if (pf_sync_r) begin
               state_nx_s = ST_ABORT;
            end else if (empty_s) begin
               done_s     = 1'b1;
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         ST_ABORT: begin
            flush_s    = 1'b1;
            fail_nx_s  = 1'b1;
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Burst state, prescaler, sample counter and sticky status.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_r <= ST_IDLE;
         presc_r <= {PRE_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
         fail_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         presc_r <= presc_nx_s;
         count_r <= count_nx_s;
         fail_r  <= fail_nx_s;
         ovf_r   <= ovf_nx_s;
      end
   end

`ifdef SENSOR_DEDUP_EN
   logic [DATA_W-1:0] last_r;
   logic              have_last_r;

   // A tick repeating the last stored word is dropped silently; the first word of a burst never matches.
   always_comb begin
      skip_s = have_last_r && (pad_sync_r == last_r);
   end

   // Track the most recently pushed word within the current burst.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         last_r      <= {DATA_W{1'b0}};
         have_last_r <= 1'b0;
      end else if (burst_entry_s) begin
         have_last_r <= 1'b0;
      end else if (push_s) begin
         last_r      <= pad_sync_r;
         have_last_r <= 1'b1;
      end
   end
`else
   assign skip_s = 1'b0;
`endif

   sync_fifo_fwft #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .push      (push_s),
      .push_data (pad_sync_r),
      .pop       (pop_s),
      .flush     (flush_s),
      .pop_data  (fifo_data_s),
      .full      (full_s),
      .empty     (empty_s),
      .level     (level_s)
   );

   assign out_valid_o = valid_s;
   assign out_data_o  = fifo_data_s;
   assign busy_o      = (state_r != ST_IDLE);
   assign done_o      = done_s;
   assign fail_o      = fail_r;
   assign overflow_o  = ovf_r;
   assign level_o     = level_s;

endmodule

// File: tb/tb_sensor_capture_frontend.sv
// Directed/randomised bench for sensor_capture_frontend with a list-based reference model.
module tb_sensor_capture_frontend;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CDIV  = 4;
   localparam int NS    = 20;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef SENSOR_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_logging = 1'b0;
   logic [DW-1:0] pad = '0;
   logic          power_fail = 1'b0;
   logic          out_ready = 1'b0;
   logic          out_valid_o;
   logic [DW-1:0] out_data_o;
   logic          busy_o;
   logic          done_o;
   logic          fail_o;
   logic          overflow_o;
   logic [LW-1:0] level_o;

   sensor_capture_frontend #(
      .DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(CDIV), .NUM_SAMPLES(NS)
   ) dut (
      .wb_clk_i      (clk),
      .wb_rst_ni     (rst_n),
      .start_logging (start_logging),
      .sensor_pad_i  (pad),
      .power_fail_i  (power_fail),
      .out_valid_o   (out_valid_o),
      .out_data_o    (out_data_o),
      .out_ready_i   (out_ready),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .fail_o        (fail_o),
      .overflow_o    (overflow_o),
      .level_o       (level_o)
   );

   always #5 clk = ~clk;

   int            total = 0;
   int            bad = 0;
   int            cyc_n = 0;
   int            done_cnt = 0;
   int            first_valid = -1;
   logic [DW-1:0] vals [NS];
   logic [DW-1:0] got [$];
   logic [DW-1:0] exp_q [$];
   bit            exp_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: log handshake transfers and done pulses seen before the edge, then step past it.
   task automatic cyc();
      if (out_valid_o && out_ready) got.push_back(out_data_o);
      if (done_o) done_cnt++;
      if (out_valid_o && first_valid < 0) first_valid = cyc_n;
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   // Reference: each tick's sample is kept unless it repeats the last kept word (dedup build)
   // or the buffer already holds DEPTH words while the consumer is stalled.
   task automatic build_expected(input bit rdy);
      bit            have;
      logic [DW-1:0] last;
      have = 1'b0;
      last = '0;
      exp_q.delete();
      exp_ovf = 1'b0;
      for (int k = 0; k < NS; k++) begin
         if (DEDUP && have && vals[k] == last) continue;
         if (!rdy && exp_q.size() >= DEPTH) begin
            exp_ovf = 1'b1;
            continue;
         end
         exp_q.push_back(vals[k]);
         have = 1'b1;
         last = vals[k];
      end
   endtask

   task automatic run_burst(input string tag, input bit rdy, input bit restart);
      int start_cyc;
      int guard;
      got.delete();
      done_cnt = 0;
      first_valid = -1;
      out_ready = rdy;
      build_expected(rdy);
      start_logging = 1'b1;
      cyc();
      start_logging = 1'b0;
      start_cyc = cyc_n;
      chk({tag, " busy"}, 32'(busy_o), 32'd1);
      chk({tag, " fail cleared"}, 32'(fail_o), 32'd0);
      for (int k = 0; k < NS; k++) begin
         pad = vals[k];
         if (restart && k == 5) start_logging = 1'b1;
         cyc();
         start_logging = 1'b0;
         repeat (CDIV - 1) cyc();
      end
      if (!rdy) begin
         chk({tag, " level held"}, 32'(level_o), 32'(exp_q.size()));
         chk({tag, " overflow"}, 32'(overflow_o), 32'(exp_ovf));
         chk({tag, " nothing delivered"}, 32'(got.size()), 32'd0);
         out_ready = 1'b1;
      end
      guard = 0;
      while (!(done_cnt > 0 && !busy_o) && guard < 200) begin
         cyc();
         guard++;
      end
      chk({tag, " finished in time"}, 32'(guard < 200), 32'd1);
      repeat (3) cyc();
      chk({tag, " done pulses"}, 32'(done_cnt), 32'd1);
      chk({tag, " overflow end"}, 32'(overflow_o), 32'(exp_ovf));
      chk({tag, " fail end"}, 32'(fail_o), 32'd0);
      chk({tag, " level end"}, 32'(level_o), 32'd0);
      chk({tag, " word count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk($sformatf("%s word%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
      if (rdy) begin
         chk({tag, " first valid latency"},
             32'(first_valid - start_cyc >= CDIV && first_valid - start_cyc <= CDIV + 2), 32'd1);
      end
   endtask

   initial begin
      int guard;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy_o), 32'd0);
      chk("reset valid", 32'(out_valid_o), 32'd0);
      chk("reset level", 32'(level_o), 32'd0);
      chk("reset flags", 32'({done_o, fail_o, overflow_o}), 32'd0);
      rst_n = 1'b1;
      repeat (2) cyc();

      // Basic ramp burst
      for (int k = 0; k < NS; k++) vals[k] = 8'h10 + 8'(k);
      run_burst("ramp", 1'b1, 1'b0);

      // Random full-range burst, then a small-alphabet burst where repeats are common
      for (int k = 0; k < NS; k++) vals[k] = 8'($urandom_range(0, 255));
      run_burst("rand", 1'b1, 1'b0);
      for (int k = 0; k < NS; k++) vals[k] = 8'($urandom_range(0, 3));
      run_burst("rand_small", 1'b1, 1'b0);

      // Backpressure: consumer stalled through the whole capture
      for (int k = 0; k < NS; k++) vals[k] = 8'($urandom_range(0, 255));
      run_burst("backpressure", 1'b0, 1'b0);

      // Constant sample stream
      for (int k = 0; k < NS; k++) vals[k] = 8'hAA;
      run_burst("const", 1'b1, 1'b0);
      chk("const delivered", 32'(got.size()), DEDUP ? 32'd1 : 32'(NS));

      // Power-fail after the third tick
      got.delete();
      done_cnt = 0;
      out_ready = 1'b0;
      start_logging = 1'b1;
      cyc();
      start_logging = 1'b0;
      for (int k = 0; k < 3; k++) begin
         pad = 8'h30 + 8'(k);
         repeat (CDIV) cyc();
      end
      chk("pf level before", 32'(level_o), 32'd3);
      power_fail = 1'b1;
      guard = 0;
      while (busy_o && guard < 10) begin
         cyc();
         guard++;
      end
      chk("pf abort bound", 32'(guard <= 4), 32'd1);
      chk("pf level", 32'(level_o), 32'd0);
      chk("pf valid", 32'(out_valid_o), 32'd0);
      chk("pf fail", 32'(fail_o), 32'd1);
      chk("pf no done", 32'(done_cnt), 32'd0);
      start_logging = 1'b1;
      cyc();
      start_logging = 1'b0;
      chk("pf start blocked", 32'(busy_o), 32'd0);
      power_fail = 1'b0;
      repeat (3) cyc();

      // Next burst clears fail_o; a start pulse mid-capture must be ignored
      for (int k = 0; k < NS; k++) vals[k] = 8'h40 + 8'(k);
      run_burst("restart_ignored", 1'b1, 1'b1);

      // Asynchronous reset in the middle of a burst
      out_ready = 1'b0;
      pad = 8'h5A;
      start_logging = 1'b1;
      cyc();
      start_logging = 1'b0;
      repeat (10) cyc();
      chk("midrst busy before", 32'(busy_o), 32'd1);
      chk("midrst level before", 32'(level_o), DEDUP ? 32'd1 : 32'd2);
      rst_n = 1'b0;
      #2;
      chk("midrst busy", 32'(busy_o), 32'd0);
      chk("midrst valid", 32'(out_valid_o), 32'd0);
      chk("midrst data", 32'(out_data_o), 32'd0);
      chk("midrst level", 32'(level_o), 32'd0);
      chk("midrst flags", 32'({done_o, fail_o, overflow_o}), 32'd0);
      #2;
      rst_n = 1'b1;
      repeat (3) cyc();
      chk("post reset idle", 32'(busy_o), 32'd0);
      chk("post reset level", 32'(level_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
